if_fetch_unit: RTL

- Instruction-fetch stage that owns the program counter and issues in-order requests to instruction memory.
- Buffers the returned instructions with their PC and PC+4, then hands them to ID/EX, where the adder forms branch targets from the PC.
- Accepts branch/jump redirects from EX and squashes all younger in-flight fetches.

---
 rtl/if_pkg.sv | 14 +
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_fifo.sv | 40 ++++
 rtl/if_fetch_unit.sv | 53 +++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared widths, reset defaults and the fetch-buffer entry type.
package if_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;
  localparam int ILEN_BYTES = 4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(ILEN_BYTES);
  endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: imem request/response, EX redirect and ID handoff signals.
interface if_fetch_unit_if #(parameter int XLEN = if_pkg::XLEN);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;
  logic [XLEN-1:0] if_instr;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_pc_plus4, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_pc_plus4, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: synchronous FIFO with flush; push is accepted when full only alongside a pop.
module if_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_q <= '0;
      wr_q <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, issues in-order imem fetches and buffers {pc, instr} for ID.
module if_fetch_unit #(
  parameter int XLEN = if_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = if_pkg::RESET_PC,
  parameter int DEPTH = if_pkg::DEPTH
) (
  input logic            clk,
  input logic            rst_n,
  if_fetch_unit_if.master bus
);
  import if_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] pc_q, tag_pc;
  logic [CW-1:0] tag_count, buf_count, drop_q;
  logic tag_full, tag_empty, buf_full, buf_empty;
  logic rsp, drop_hit, accept, unused_ok;
  fetch_entry_t head, rsp_entry;
  // Tag FIFO occupancy is exactly the number of requests still awaiting a response.
  assign rsp = bus.imem_rsp_valid & ~tag_empty;
  assign drop_hit = rsp & (drop_q != '0);
  assign bus.imem_req_valid = rst_n & ~bus.redirect_valid & (int'(tag_count) + int'(buf_count) < DEPTH);
  assign bus.imem_req_addr = pc_q;
  assign accept = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_entry = '{pc: tag_pc, instr: bus.imem_rsp_data};
  assign bus.if_valid = rst_n & ~buf_empty;
  assign bus.if_pc = rst_n ? head.pc : '0;
  assign bus.if_pc_plus4 = rst_n ? next_pc(head.pc) : '0;
  assign bus.if_instr = rst_n ? head.instr : '0;
  assign unused_ok = &{1'b0, tag_full, buf_full};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      drop_q <= '0;
    end else if (bus.redirect_valid) begin
      pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      drop_q <= tag_count - CW'(rsp);
    end else begin
      if (accept) pc_q <= next_pc(pc_q);
      if (drop_hit) drop_q <= drop_q - 1'b1;
    end
  end
  if_fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .push(accept), .din(pc_q), .pop(rsp), .dout(tag_pc),
    .count(tag_count), .full(tag_full), .empty(tag_empty)
  );
  // Redirect flush takes priority over a same-cycle push or pop inside the FIFO.
  if_fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst_n(rst_n), .flush(bus.redirect_valid),
    .push(rsp & ~drop_hit), .din(rsp_entry), .pop(bus.if_valid & bus.if_ready), .dout(head),
    .count(buf_count), .full(buf_full), .empty(buf_empty)
  );
endmodule
